fcvt_int2f_seq: RTL and testbench
=================================

Name: fcvt_int2f_seq

Overview:
- Multi-cycle sequencer that converts a signed or unsigned integer to an IEEE-754 single-precision value for the FPU's FCVT.S.W and FCVT.S.WU instructions.
- Owns one combinational leading-zero counter of width W_IN and steps the datapath through magnitude, normalize and round/pack stages.
- Sits between the FPU issue logic and the FPU writeback mux. Uses a valid/ready handshake on both sides.

Parameters:
- W_IN, 32, integer operand width. Legal values are 32 and 64 (power of 2, as the leading-zero counter requires).
- W_LZ, $clog2(W_IN), width of the leading-zero count.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- resetn  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand valid.
- in_ready  output  1  block can accept an operand.
- in_data  input  W_IN  integer operand.
- in_signed  input  1  1 = treat in_data as two's complement (FCVT.S.W); 0 = unsigned (FCVT.S.WU).
- in_rm  input  3  RISC-V rounding mode: 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_result  output  32  single-precision result.
- out_fflags  output  5  {NV,DZ,OF,UF,NX}; only NX is ever set.

Behaviour:
- Reset: asynchronous on resetn low.
  - State goes to IDLE; out_valid=0, out_result=0, out_fflags=0; all internal registers cleared.
  - in_ready=0 while resetn low, 1 in IDLE thereafter.
  - Reset mid-operation abandons the conversion; no result is ever emitted for it.
- FSM states: IDLE -> ABS -> NORM -> RND -> OUT -> IDLE.
  - IDLE: in_ready=1. On in_valid&in_ready, latch in_data, in_signed and in_rm, then go to ABS.
  - ABS: sign = in_signed & data[W_IN-1]. mag = sign ? -data : data, held in W_IN bits unsigned, so the most negative value yields 2^(W_IN-1) correctly. Go to NORM.
  - NORM: lz = CLZ(mag); norm = mag << lz; zero = (mag==0). Register all three, then go to RND.
  - RND: pack the result and go to OUT.
    - frac = norm[W_IN-2 -: 23]; guard = norm[W_IN-25]; sticky = OR of norm[W_IN-26:0].
    - exp = 127 + (W_IN-1) - lz.
    - Round-up condition by mode:
      - RNE: guard & (sticky | frac[0]).
      - RTZ: 0.
      - RDN: sign & (guard|sticky).
      - RUP: ~sign & (guard|sticky).
      - RMM: guard.
    - rm values 101, 110 and 111 are treated as RNE.
    - frac+1 carry-out: frac=0 and exp+1.
    - NX = guard|sticky.
    - zero: result = 32'h00000000 (always +0, even for signed input) and fflags=0.
    - Otherwise result = {sign, exp[7:0], frac} and fflags = {4'b0, NX}.
  - OUT: out_valid=1, with out_result and out_fflags held stable. On out_ready, clear out_valid and go to IDLE.
- Latency: out_valid rises exactly 4 cycles after the accepting edge.
  - Throughput is at most one conversion per 5 cycles.
  - With out_ready held high, the next operand is accepted no earlier than 1 cycle after out_valid falls.
- in_ready=0 in every non-IDLE state. in_valid outside IDLE is ignored and does not need to be held stable.
- out_valid must not drop without out_ready. Backpressure of any length holds the result unchanged.
- Overflow to infinity cannot occur (max exp = 127+W_IN ≤ 191). OF, UF, NV and DZ are always 0.
- Leading-zero counter instanced once. Its output is undefined for zero input, which is why the zero flag overrides it.

Test Plan:
- Unsigned 1, RNE -> 32'h3F800000, fflags 0, out_valid 4 cycles after accept.
- Signed 32'hFFFFFFFF (-1), RTZ -> 32'hBF800000, fflags 0. Signed 32'h80000000 -> 32'hCF000000, exact, NX=0.
- Unsigned 32'hFFFFFFFF, RNE -> rounding carry, 32'h4F800000, NX=1. Same input with RTZ -> 32'h4F7FFFFF, NX=1.
- Unsigned 32'h01000001 in each mode:
  - RNE -> 32'h4B800000.
  - RUP -> 32'h4B800001.
  - RDN -> 32'h4B800000.
  - All three set NX=1.
  - Signed 32'hFEFFFFFF in RDN -> 32'hCB800001.
- Zero input, signed, RDN -> 32'h00000000, fflags 0. Backpressure: hold out_ready=0 for 10 cycles -> result stable, in_ready=0 throughout, in_valid pulses ignored.
- Assert resetn low during NORM -> out_valid=0 immediately, no stale result. After release, a new operand (unsigned 5) -> 32'h40A00000.

Source files
------------

// File: rtl/fcvt_int2f_seq.sv
// Multi-cycle int32/int64 -> IEEE-754 single converter (FCVT.S.W / FCVT.S.WU).
// One state per datapath stage: latch, magnitude, normalize, round/pack, present.

module fcvt_int2f_lzc #(
  parameter int W  = 32,
  parameter int WL = $clog2(W)
) (
  input  logic [W-1:0]  a_i,
  output logic [WL-1:0] cnt_o
);
  // Highest set bit wins; the all-zero case is don't-care upstream.
  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < W; i++)
      if (a_i[i]) cnt_o = WL'(W - 1 - i);
  end
endmodule

module fcvt_int2f_seq #(
  parameter int W_IN = 32,
  parameter int W_LZ = $clog2(W_IN)
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W_IN-1:0] in_data,
  input  logic            in_signed,
  input  logic [2:0]      in_rm,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_result,
  output logic [4:0]      out_fflags
);

  typedef enum logic [2:0] {S_IDLE, S_ABS, S_NORM, S_RND, S_OUT} state_e;

  state_e state_q, state_d;

  logic [W_IN-1:0] data_q, mag_q, norm_q;
  logic            sgn_in_q, sign_q, zero_q;
  logic [2:0]      rm_q;
  logic [W_LZ-1:0] lz_q, lz_w;
  logic [31:0]     res_q, res_d;
  logic [4:0]      flags_q, flags_d;

  logic [22:0] frac, frac_r;
  logic [23:0] frac_inc;
  logic        guard, sticky, rnd_up, neg;
  logic [7:0]  exp_w, exp_r;

  fcvt_int2f_lzc #(.W(W_IN), .WL(W_LZ)) u_lzc (.a_i(mag_q), .cnt_o(lz_w));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (in_valid) state_d = S_ABS;
      S_ABS:   state_d = S_NORM;
      S_NORM:  state_d = S_RND;
      S_RND:   state_d = S_OUT;
      S_OUT:   if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign neg = sgn_in_q & data_q[W_IN-1];

  // Round/pack from the normalized magnitude (leading one at bit W_IN-1).
  always_comb begin
    frac   = norm_q[W_IN-2 -: 23];
    guard  = norm_q[W_IN-25];
    sticky = |norm_q[W_IN-26:0];
    exp_w  = 8'(127 + W_IN - 1) - 8'(lz_q);
    unique case (rm_q)
      3'b001:  rnd_up = 1'b0;
      3'b010:  rnd_up = sign_q & (guard | sticky);
      3'b011:  rnd_up = ~sign_q & (guard | sticky);
      3'b100:  rnd_up = guard;
      default: rnd_up = guard & (sticky | frac[0]);
    endcase
    frac_inc = {1'b0, frac} + 24'(rnd_up);
    if (frac_inc[23]) begin
      frac_r = '0;
      exp_r  = exp_w + 8'd1;
    end else begin
      frac_r = frac_inc[22:0];
      exp_r  = exp_w;
    end
    res_d   = zero_q ? 32'h0 : {sign_q, exp_r, frac_r};
    flags_d = zero_q ? 5'h0  : {4'b0, guard | sticky};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      data_q   <= '0;
      sgn_in_q <= 1'b0;
      rm_q     <= '0;
      sign_q   <= 1'b0;
      mag_q    <= '0;
      norm_q   <= '0;
      lz_q     <= '0;
      zero_q   <= 1'b0;
      res_q    <= '0;
      flags_q  <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: if (in_valid) begin
          data_q   <= in_data;
          sgn_in_q <= in_signed;
          rm_q     <= in_rm;
        end
        S_ABS: begin
          sign_q <= neg;
          mag_q  <= neg ? -data_q : data_q;
        end
        S_NORM: begin
          norm_q <= mag_q << lz_w;
          lz_q   <= lz_w;
          zero_q <= ~|mag_q;
        end
        S_RND: begin
          res_q   <= res_d;
          flags_q <= flags_d;
        end
        default: ;
      endcase
    end
  end

  assign in_ready   = (state_q == S_IDLE) && resetn;
  assign out_valid  = (state_q == S_OUT);
  assign out_result = res_q;
  assign out_fflags = flags_q;

endmodule

// File: tb/tb_fcvt_int2f_seq.sv
// Directed bench for fcvt_int2f_seq: hand-computed vectors, handshake timing, reset abort.

module tb_fcvt_int2f_seq;
  logic        clk, resetn;
  logic        in_valid, in_ready, in_signed, out_valid, out_ready;
  logic [31:0] in_data, out_result;
  logic [2:0]  in_rm;
  logic [4:0]  out_fflags;
  int          checks, errors;

  fcvt_int2f_seq #(.W_IN(32)) dut (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_signed(in_signed), .in_rm(in_rm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_fflags(out_fflags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one operand, expects out_valid 3 edges after the accepting edge
  // (i.e. in the 4th cycle after the handshake cycle), checks result and flags.
  task automatic do_conv(input logic [31:0] d, input logic s, input logic [2:0] rm,
                         input logic [31:0] er, input logic [4:0] ef, input string nm);
    int n;
    in_data = d; in_signed = s; in_rm = rm; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL %s in_ready got %b want 1", nm, in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
    checks++;
    if (n !== 3) begin errors++; $display("FAIL %s latency got %0d want 3 edges", nm, n); end
    checks++;
    if (out_result !== er) begin errors++; $display("FAIL %s result got %h want %h", nm, out_result, er); end
    checks++;
    if (out_fflags !== ef) begin errors++; $display("FAIL %s fflags got %b want %b", nm, out_fflags, ef); end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL %s out_valid after drain got %b want 0", nm, out_valid); end
  endtask

  task automatic test_reset();
    resetn = 1'b0; in_valid = 1'b0; in_data = '0; in_signed = 1'b0; in_rm = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0)
      begin errors++; $display("FAIL reset hs got rdy=%b vld=%b want 0 0", in_ready, out_valid); end
    checks++;
    if (out_result !== 32'h0 || out_fflags !== 5'h0)
      begin errors++; $display("FAIL reset data got %h/%b want 0/0", out_result, out_fflags); end
    resetn = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset idle in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_basic();
    do_conv(32'h00000001, 1'b0, 3'b000, 32'h3F800000, 5'h00, "u1_rne");
    do_conv(32'hFFFFFFFF, 1'b1, 3'b001, 32'hBF800000, 5'h00, "sm1_rtz");
    do_conv(32'h80000000, 1'b1, 3'b000, 32'hCF000000, 5'h00, "smin");
    do_conv(32'h00000005, 1'b0, 3'b000, 32'h40A00000, 5'h00, "u5");
  endtask

  task automatic test_rounding();
    do_conv(32'hFFFFFFFF, 1'b0, 3'b000, 32'h4F800000, 5'h01, "umax_rne_carry");
    do_conv(32'hFFFFFFFF, 1'b0, 3'b001, 32'h4F7FFFFF, 5'h01, "umax_rtz");
    do_conv(32'h01000001, 1'b0, 3'b000, 32'h4B800000, 5'h01, "tie_rne");
    do_conv(32'h01000001, 1'b0, 3'b011, 32'h4B800001, 5'h01, "tie_rup");
    do_conv(32'h01000001, 1'b0, 3'b010, 32'h4B800000, 5'h01, "tie_rdn");
    do_conv(32'h01000001, 1'b0, 3'b100, 32'h4B800001, 5'h01, "tie_rmm");
    do_conv(32'h01000001, 1'b0, 3'b001, 32'h4B800000, 5'h01, "tie_rtz");
    do_conv(32'hFEFFFFFF, 1'b1, 3'b010, 32'hCB800001, 5'h01, "neg_rdn");
    do_conv(32'hFEFFFFFF, 1'b1, 3'b011, 32'hCB800000, 5'h01, "neg_rup");
    do_conv(32'h01000003, 1'b0, 3'b111, 32'h4B800002, 5'h01, "rm111_as_rne");
    do_conv(32'h01000003, 1'b0, 3'b001, 32'h4B800001, 5'h01, "odd_rtz");
  endtask

  task automatic test_zero();
    do_conv(32'h00000000, 1'b1, 3'b010, 32'h00000000, 5'h00, "zero_s_rdn");
    do_conv(32'h00000000, 1'b0, 3'b011, 32'h00000000, 5'h00, "zero_u_rup");
  endtask

  task automatic test_backpressure();
    int n;
    out_ready = 1'b0;
    in_data = 32'hFFFFFFFF; in_signed = 1'b0; in_rm = 3'b000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0]; in_data = 32'h00000001 + 32'(i); in_rm = 3'b001;
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || out_result !== 32'h4F800000 || out_fflags !== 5'h01 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp cyc%0d got vld=%b res=%h ff=%b rdy=%b want 1 4f800000 00001 0",
                 i, out_valid, out_result, out_fflags, in_ready);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      begin errors++; $display("FAIL bp release got vld=%b rdy=%b want 0 1", out_valid, in_ready); end
  endtask

  task automatic test_back_to_back();
    int n;
    out_ready = 1'b1;
    in_data = 32'h00000001; in_signed = 1'b0; in_rm = 3'b000; in_valid = 1'b1;
    n = 0;
    while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    n = 1;
    while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
    checks++;
    if (n !== 5) begin errors++; $display("FAIL b2b spacing got %0d want 5", n); end
    checks++;
    if (out_result !== 32'h3F800000) begin errors++; $display("FAIL b2b result got %h want 3f800000", out_result); end
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int seen;
    in_data = 32'hFFFFFFFF; in_signed = 1'b1; in_rm = 3'b000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0)
      begin errors++; $display("FAIL rst_mid got vld=%b rdy=%b want 0 0", out_valid, in_ready); end
    @(posedge clk); #1;
    resetn = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL rst_mid stale got %0d valid cycles want 0", seen); end
    checks++;
    if (out_result !== 32'h0) begin errors++; $display("FAIL rst_mid result got %h want 0", out_result); end
    do_conv(32'h00000005, 1'b0, 3'b000, 32'h40A00000, 5'h00, "post_rst_u5");
  endtask

  initial begin
    checks = 0; errors = 0;
    test_reset();
    test_basic();
    test_rounding();
    test_zero();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
